// File: rtl/scarv_cop_rng_pool.sv
// Entropy conditioning pool: repetition-count health test, von Neumann
// debiasing, 32-bit packing and a small show-ahead FIFO for the RNG block.
module scarv_cop_rng_pool #(
    parameter int DEPTH     = 4,
    parameter int REP_LIMIT = 16
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     ent_valid,
    input  logic                     ent_bit,
    input  logic                     pool_clear,
    input  logic                     pool_pop,
    output logic                     pool_valid,
    output logic [31:0]              pool_data,
    output logic [$clog2(DEPTH):0]   pool_count,
    output logic                     pool_health_fail
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [7:0]    RLIM = 8'(REP_LIMIT);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    rep_q, rep_d, rep_nxt;
    logic          last_q, last_d;
    logic          fail_q, fail_d;
    logic          pair_vld_q, pair_vld_d, pair_bit_q, pair_bit_d;
    logic [4:0]    pk_cnt_q, pk_cnt_d;
    logic [31:0]   pk_word_q, pk_word_d, pk_word_nxt;
    logic          trip, emit, push, pop_ok;

    assign pool_valid       = !fail_q && (count_q != '0);
    assign pool_data        = pool_valid ? mem[rd_ptr_q] : 32'h0;
    assign pool_count       = fail_q ? '0 : count_q;
    assign pool_health_fail = fail_q;

    assign rep_nxt     = (ent_bit == last_q && rep_q != 8'd0) ? rep_q + 8'd1 : 8'd1;
    assign trip        = ent_valid && (rep_nxt == RLIM);
    assign pk_word_nxt = pk_word_q | (32'(pair_bit_q) << pk_cnt_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rep_d      = rep_q;
        last_d     = last_q;
        fail_d     = fail_q;
        pair_vld_d = pair_vld_q;
        pair_bit_d = pair_bit_q;
        pk_cnt_d   = pk_cnt_q;
        pk_word_d  = pk_word_q;
        emit       = 1'b0;
        push       = 1'b0;
        pop_ok     = pool_pop && pool_valid;
        if (pool_clear) begin
            pop_ok     = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rep_d      = '0;
            last_d     = 1'b0;
            fail_d     = 1'b0;
            pair_vld_d = 1'b0;
            pair_bit_d = 1'b0;
            pk_cnt_d   = '0;
            pk_word_d  = '0;
        end else if (!fail_q) begin
            if (ent_valid) begin
                rep_d  = rep_nxt;
                last_d = ent_bit;
                if (!pair_vld_q) begin
                    pair_vld_d = 1'b1;
                    pair_bit_d = ent_bit;
                end else begin
                    pair_vld_d = 1'b0;
                    emit       = (pair_bit_q != ent_bit);
                end
            end
            if (trip) begin
                // Health trip discards the current bit and everything buffered.
                pop_ok     = 1'b0;
                fail_d     = 1'b1;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
                pair_vld_d = 1'b0;
                pair_bit_d = 1'b0;
                pk_cnt_d   = '0;
                pk_word_d  = '0;
            end else begin
                if (emit) begin
                    pk_cnt_d  = pk_cnt_q + 5'd1;
                    pk_word_d = pk_word_nxt;
                    if (pk_cnt_q == 5'd31) begin
                        // Full FIFO without a pop drops the word; packer restarts regardless.
                        push      = (count_q != FULL) || pop_ok;
                        pk_word_d = '0;
                    end
                end
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
                if (push && !pop_ok) count_d = count_q + 1'b1;
                else if (pop_ok && !push) count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (push) mem[wr_ptr_q] <= pk_word_nxt;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rep_q      <= '0;
            last_q     <= 1'b0;
            fail_q     <= 1'b0;
            pair_vld_q <= 1'b0;
            pair_bit_q <= 1'b0;
            pk_cnt_q   <= '0;
            pk_word_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rep_q      <= rep_d;
            last_q     <= last_d;
            fail_q     <= fail_d;
            pair_vld_q <= pair_vld_d;
            pair_bit_q <= pair_bit_d;
            pk_cnt_q   <= pk_cnt_d;
            pk_word_q  <= pk_word_d;
        end
    end
endmodule

// File: tb/tb_scarv_cop_rng_pool.sv
// Directed bench for scarv_cop_rng_pool with hand-computed expectations.
module tb_scarv_cop_rng_pool;
    logic        g_clk = 1'b0, g_resetn = 1'b0;
    logic        ent_valid = 1'b0, ent_bit = 1'b0, pool_clear = 1'b0, pool_pop = 1'b0;
    logic        pool_valid, pool_health_fail;
    logic [31:0] pool_data;
    logic [2:0]  pool_count;
    int checks = 0, failures = 0;

    scarv_cop_rng_pool #(.DEPTH(4), .REP_LIMIT(16)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .ent_valid(ent_valid), .ent_bit(ent_bit),
        .pool_clear(pool_clear), .pool_pop(pool_pop), .pool_valid(pool_valid),
        .pool_data(pool_data), .pool_count(pool_count), .pool_health_fail(pool_health_fail)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic pop = 1'b0);
        ent_valid = 1'b1; ent_bit = b; pool_pop = pop;
        @(posedge g_clk); #1;
        ent_valid = 1'b0; pool_pop = 1'b0;
    endtask

    task automatic pair(input logic a, input logic b);
        send_bit(a); send_bit(b);
    endtask

    task automatic word55();
        for (int i = 0; i < 16; i++) begin pair(1, 0); pair(0, 1); end
    endtask

    task automatic wordff();
        for (int i = 0; i < 32; i++) pair(1, 0);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk(tag, {pool_valid, pool_data}, {1'b1, exp});
        pool_pop = 1'b1;
        @(posedge g_clk); #1;
        pool_pop = 1'b0;
    endtask

    task automatic clear();
        pool_clear = 1'b1;
        @(posedge g_clk); #1;
        pool_clear = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_outs", {pool_valid, pool_health_fail, pool_count, pool_data}, '0);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;

        // 0x55555555 from alternating "10","01"
        for (int i = 0; i < 15; i++) begin pair(1, 0); pair(0, 1); end
        pair(1, 0); send_bit(0);
        chk("w55_partial", {pool_valid, pool_count}, {1'b0, 3'd0});
        send_bit(1);
        chk("w55_ready", {pool_valid, pool_count, pool_data}, {1'b1, 3'd1, 32'h55555555});
        pop_chk("w55_pop", 32'h55555555);

        // equal pairs contribute nothing
        for (int i = 0; i < 64; i++) begin
            pair(1, 0);
            if (i[0]) pair(1, 1); else pair(0, 0);
        end
        chk("ff_count", pool_count, 3'd2);
        pop_chk("ff_pop0", 32'hFFFFFFFF);
        pop_chk("ff_pop1", 32'hFFFFFFFF);

        // overflow drop
        for (int i = 0; i < 4; i++) word55();
        chk("full_count", pool_count, 3'd4);
        wordff();
        chk("drop_count", pool_count, 3'd4);
        for (int i = 0; i < 4; i++) pop_chk("drop_pop", 32'h55555555);
        chk("drop_empty", {pool_valid, pool_count, pool_data}, '0);

        // push and pop together at full
        for (int i = 0; i < 4; i++) word55();
        for (int i = 0; i < 31; i++) pair(1, 0);
        send_bit(1); send_bit(0, 1'b1);
        chk("pp_count", pool_count, 3'd4);
        for (int i = 0; i < 3; i++) pop_chk("pp_pop", 32'h55555555);
        pop_chk("pp_pop_last", 32'hFFFFFFFF);
        pool_pop = 1'b1; @(posedge g_clk); #1; pool_pop = 1'b0;
        chk("pop_empty", {pool_valid, pool_count, pool_data}, '0);

        // health test: last buffered bit is 0, so 16 ones trip exactly on the 16th
        clear();
        wordff(); wordff();
        for (int i = 0; i < 15; i++) send_bit(1);
        chk("rep15", {pool_health_fail, pool_count}, {1'b0, 3'd2});
        send_bit(1);
        chk("rep16", {pool_health_fail, pool_valid, pool_count, pool_data}, {1'b1, 1'b0, 3'd0, 32'h0});
        send_bit(0); send_bit(1, 1'b1);
        chk("fail_hold", {pool_health_fail, pool_valid, pool_count}, {1'b1, 1'b0, 3'd0});
        clear();
        chk("fail_clear", {pool_health_fail, pool_valid, pool_count}, '0);

        // async reset mid-word
        word55(); word55(); word55();
        chk("pre_rst", pool_count, 3'd3);
        for (int i = 0; i < 10; i++) pair(1, 0);
        send_bit(1);
        #3 g_resetn = 1'b0;
        #1 chk("async_rst", {pool_valid, pool_health_fail, pool_count, pool_data}, '0);
        #10 g_resetn = 1'b1;
        @(posedge g_clk); #1;
        for (int i = 0; i < 15; i++) begin pair(1, 0); pair(0, 1); end
        pair(1, 0);
        chk("post_rst_partial", pool_count, 3'd0);
        pair(0, 1);
        chk("post_rst_word", {pool_valid, pool_count, pool_data}, {1'b1, 3'd1, 32'h55555555});
        pool_pop = 1'b1; @(posedge g_clk); #1; pool_pop = 1'b0;
        chk("post_rst_one", {pool_valid, pool_count}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
